// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - multi-cycle RV32I data memory with byte lanes, sign extension and error reporting
module data_memory_ctrl #(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int LATENCY      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            func3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic [DATA_WIDTH-1:0] rData,
  output logic                  ready,
  output logic                  error
);

  localparam int AW = $clog2(DM_MEM_DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [31:0] mem [DM_MEM_DEPTH];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          error_q, error_d;

  // latched request; datapath only, never needs a reset value
  logic [AW+1:0] addr_q;
  logic [2:0]    func3_q;
  logic [31:0]   wdata_q;
  logic          is_rd_q, is_wr_q;

  logic [AW+1:0] op_addr;
  logic [2:0]    op_f3;
  logic [31:0]   op_wd;
  logic          op_rd, op_wr;
  logic          accept, finish, bad, do_write;
  logic          illegal, misaligned;
  logic [AW-1:0] op_idx;
  logic [31:0]   mem_word, shifted, load_val, wd_lanes, merged;
  logic [3:0]    be;

  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  // With LATENCY=1 the access completes on the accept edge, so use the live inputs in IDLE
  always_comb begin
    if (state_q == S_IDLE) begin
      op_addr = addr[AW+1:0];
      op_f3   = func3;
      op_wd   = wData;
      op_rd   = memRead;
      op_wr   = memWrite;
    end else begin
      op_addr = addr_q;
      op_f3   = func3_q;
      op_wd   = wdata_q;
      op_rd   = is_rd_q;
      op_wr   = is_wr_q;
    end
  end

  // Decode legality, alignment, load extension and store lane merge
  always_comb begin
    op_idx     = op_addr[AW+1:2];
    mem_word   = mem[op_idx];
    illegal    = (op_rd && op_wr) ||
                 (op_rd && !(op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                 (op_wr && !(op_f3 inside {3'b000, 3'b001, 3'b010}));
    misaligned = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    bad        = illegal || misaligned;
    shifted    = mem_word >> {op_addr[1:0], 3'b000};
    case (op_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = mem_word;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = 32'd0;
    endcase
    case (op_f3[1:0])
      2'b00: begin
        be       = 4'b0001 << op_addr[1:0];
        wd_lanes = {4{op_wd[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << op_addr[1:0];
        wd_lanes = {2{op_wd[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = op_wd;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wd_lanes[8*i +: 8] : mem_word[8*i +: 8];
    end
  end

  // Next-state: IDLE accepts, WAIT counts down, DONE pulses ready for one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memRead || memWrite) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_DONE;
            finish  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          finish  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d  = finish;
    error_d  = finish && bad;
    rdata_d  = rdata_q;
    if (finish) begin
      if (bad) begin
        rdata_d = 32'd0;
      end else if (op_rd) begin
        rdata_d = load_val;
      end
    end
    do_write = finish && op_wr && !bad && !rst;
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr[AW+1:0];
      func3_q <= func3;
      wdata_q <= wData;
      is_rd_q <= memRead;
      is_wr_q <= memWrite;
    end
  end

  // Array write on the edge entering DONE; contents are never reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[op_idx] <= merged;
    end
  end

  assign rData = rdata_q;
  assign ready = ready_q;
  assign error = error_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata, rdata;
  logic        ready, error;
  logic        mem_read1, mem_write1;
  logic [2:0]  func3_1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, error1;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_ctrl #(.DM_MEM_DEPTH(4096), .DATA_WIDTH(32), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .memRead(mem_read), .memWrite(mem_write), .func3(func3),
    .addr(addr), .wData(wdata), .rData(rdata), .ready(ready), .error(error)
  );

  data_memory_ctrl #(.DM_MEM_DEPTH(4096), .DATA_WIDTH(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .memRead(mem_read1), .memWrite(mem_write1), .func3(func3_1),
    .addr(addr1), .wData(wdata1), .rData(rdata1), .ready(ready1), .error(error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs already deasserted after the accept edge; find the ready pulse within a bound
  task automatic wait_done(output logic [31:0] r, output logic e, output int lat);
    lat = 0;
    r   = 32'd0;
    e   = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        r   = rdata;
        e   = error;
        break;
      end
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] r, output logic e, output int lat);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; func3 = f; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    wait_done(r, e, lat);
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;

  logic        b_rd [5];
  logic        b_wr [5];
  logic [2:0]  b_f3 [5];
  logic [31:0] b_ad [5];
  logic [31:0] b_wd [5];
  logic [31:0] b_er [5];
  logic [31:0] b_ev [5];

  task automatic drive1(input int k);
    mem_read1 = b_rd[k]; mem_write1 = b_wr[k]; func3_1 = b_f3[k]; addr1 = b_ad[k]; wdata1 = b_wd[k];
  endtask

  initial begin
    int cyc, last, pulses;
    rst = 1'b1;
    mem_read = 0; mem_write = 0; func3 = 0; addr = 0; wdata = 0;
    mem_read1 = 0; mem_write1 = 0; func3_1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, lat);
    check("sw_lat", lat, 2);
    check("sw_err", {31'd0, e}, 32'd0);
    check("sw_rdata_kept", r, 32'd0);
    do_req(1, 0, 3'b010, 32'h10, 32'd0, r, e, lat);
    check("lw_lat", lat, 2);
    check("lw_data", r, 32'hDEADBEEF);
    check("lw_err", {31'd0, e}, 32'd0);

    do_req(0, 1, 3'b000, 32'h11, 32'h000000AA, r, e, lat);
    check("sb_rdata_kept", r, 32'hDEADBEEF);
    do_req(1, 0, 3'b010, 32'h10, 32'd0, r, e, lat);
    check("sb_merge", r, 32'hDEADAAEF);

    do_req(0, 1, 3'b010, 32'h10, 32'hDEAD80EF, r, e, lat);
    do_req(1, 0, 3'b000, 32'h11, 32'd0, r, e, lat);
    check("lb", r, 32'hFFFFFF80);
    do_req(1, 0, 3'b100, 32'h11, 32'd0, r, e, lat);
    check("lbu", r, 32'h00000080);
    do_req(1, 0, 3'b001, 32'h12, 32'd0, r, e, lat);
    check("lh", r, 32'hFFFFDEAD);
    do_req(1, 0, 3'b101, 32'h12, 32'd0, r, e, lat);
    check("lhu", r, 32'h0000DEAD);

    do_req(1, 0, 3'b010, 32'h13, 32'd0, r, e, lat);
    check("lw_mis_err", {31'd0, e}, 32'd1);
    check("lw_mis_rdata", r, 32'd0);
    check("lw_mis_lat", lat, 2);
    do_req(1, 0, 3'b101, 32'h12, 32'd0, r, e, lat);
    do_req(0, 1, 3'b001, 32'h11, 32'h00001234, r, e, lat);
    check("sh_mis_err", {31'd0, e}, 32'd1);
    check("sh_mis_rdata", r, 32'd0);
    do_req(1, 0, 3'b101, 32'h12, 32'd0, r, e, lat);
    do_req(1, 0, 3'b011, 32'h10, 32'd0, r, e, lat);
    check("ld_f3_011_err", {31'd0, e}, 32'd1);
    check("ld_f3_011_rdata", r, 32'd0);
    do_req(0, 1, 3'b011, 32'h10, 32'h55555555, r, e, lat);
    check("st_f3_011_err", {31'd0, e}, 32'd1);
    do_req(1, 1, 3'b010, 32'h10, 32'h66666666, r, e, lat);
    check("rd_wr_both_err", {31'd0, e}, 32'd1);
    do_req(1, 0, 3'b010, 32'h10, 32'd0, r, e, lat);
    check("bad_no_write", r, 32'hDEAD80EF);
    check("good_err_clear", {31'd0, e}, 32'd0);

    do_req(0, 1, 3'b010, 32'h4000, 32'h12345678, r, e, lat);
    do_req(1, 0, 3'b010, 32'h0, 32'd0, r, e, lat);
    check("wrap", r, 32'h12345678);

    do_req(0, 1, 3'b010, 32'h20, 32'h11111111, r, e, lat);
    @(posedge clk); #1;
    mem_write = 1'b1; func3 = 3'b010; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h20;
    @(negedge clk);
    check("abort_no_ready", {31'd0, ready}, 32'd0);
    check("abort_rdata_rst", rdata, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    wait_done(r, e, lat);
    check("after_rst_lat", lat, 2);
    check("abort_no_write", r, 32'h11111111);

    b_rd[0] = 0; b_wr[0] = 1; b_f3[0] = 3'b010; b_ad[0] = 32'h4; b_wd[0] = 32'h01020304; b_er[0] = 0; b_ev[0] = 32'h0;
    b_rd[1] = 1; b_wr[1] = 0; b_f3[1] = 3'b010; b_ad[1] = 32'h4; b_wd[1] = 32'h0;        b_er[1] = 0; b_ev[1] = 32'h01020304;
    b_rd[2] = 0; b_wr[2] = 1; b_f3[2] = 3'b000; b_ad[2] = 32'h5; b_wd[2] = 32'h000000FF; b_er[2] = 0; b_ev[2] = 32'h01020304;
    b_rd[3] = 1; b_wr[3] = 0; b_f3[3] = 3'b001; b_ad[3] = 32'h5; b_wd[3] = 32'h0;        b_er[3] = 1; b_ev[3] = 32'h0;
    b_rd[4] = 1; b_wr[4] = 0; b_f3[4] = 3'b010; b_ad[4] = 32'h4; b_wd[4] = 32'h0;        b_er[4] = 0; b_ev[4] = 32'h0102FF04;
    @(posedge clk); #1;
    drive1(0);
    cyc = 0; last = 0; pulses = 0;
    while (pulses < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready1) begin
        check($sformatf("b2b_err%0d", pulses), {31'd0, error1}, b_er[pulses]);
        check($sformatf("b2b_data%0d", pulses), rdata1, b_ev[pulses]);
        if (pulses > 0) check($sformatf("b2b_gap%0d", pulses), cyc - last, 2);
        last = cyc;
        pulses++;
        if (pulses < 5) drive1(pulses);
        else begin
          mem_read1 = 1'b0; mem_write1 = 1'b0;
        end
      end
    end
    check("b2b_pulses", pulses, 5);
    check("b2b_first", last - 8, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Parameters
REQ-001 SHALL have parameter DM_MEM_DEPTH, default 4096: number of 32-bit words in the internal array; a power of two, at least 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request acceptance to ready; integer, at least 1.

Interface
REQ-004 SHALL have clk, input, 1: single clock, rising edge.
REQ-005 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have memRead, input, 1: load request from the processor MEM stage.
REQ-007 SHALL have memWrite, input, 1: store request from the processor MEM stage.
REQ-008 SHALL have func3, input, 3: RV32I load/store width code.
REQ-009 SHALL have addr, input, 32: byte address (the ALU result).
REQ-010 SHALL have wData, input, 32: store data (rs2), with byte lanes taken from the LSBs.
REQ-011 SHALL have rData, output, 32: load result, sign- or zero-extended.
REQ-012 SHALL have ready, output, 1: one-cycle completion pulse; the processor stalls while a request is present and ready is 0.
REQ-013 SHALL have error, output, 1: the completed request was misaligned or illegal; valid only when ready is 1.

Function
REQ-014 SHALL implement a state machine with three states, IDLE, WAIT and DONE; all outputs are registered.
REQ-015 IDLE: when memRead or memWrite is 1, the block SHALL latch addr, func3, wData and the request type, then go to WAIT with the count set to LATENCY-1; if LATENCY is 1, it goes directly to DONE.
REQ-016 WAIT: the count SHALL decrement each cycle and the block goes to DONE when it is 0; request inputs are ignored while in WAIT.
REQ-017 DONE: ready SHALL be 1 for exactly one cycle, and the block then returns to IDLE; a request present in that next IDLE cycle is accepted as a new request.
REQ-018 Latency: a request accepted in cycle t SHALL see ready=1 in cycle t+LATENCY; ready is 0 in IDLE and in WAIT.
REQ-019 The word index SHALL be latched addr[$clog2(DM_MEM_DEPTH)+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
REQ-020 Byte lanes SHALL be little-endian: byte n is bits [8n+7:8n], selected by addr[1:0].
REQ-021 Loads SHALL decode func3 as 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend) and 101 LHU (zero-extend).
REQ-022 Stores SHALL decode func3 as 000 SB, 001 SH and 010 SW; only the addressed lanes are written, and the other lanes of the word are preserved.
REQ-023 The array write and the rData update SHALL take effect on the clock edge that enters DONE, so both are visible in the same cycle that ready=1.
REQ-024 After a successful load, rData SHALL hold the result from the DONE cycle until the next successful load completes; stores leave rData unchanged.
REQ-025 An access SHALL be treated as misaligned when it is a halfword access with addr[0]=1, or a word access with addr[1:0]≠00.
REQ-026 A func3 value not listed above, or memRead and memWrite both 1, SHALL be treated as illegal.
REQ-027 For a misaligned or illegal request, the block SHALL perform no write, drive rData=0, and drive error=1 with ready; error is 0 otherwise.
REQ-028 Array contents SHALL be undefined at power-up and are not cleared by rst.

Reset
REQ-029 While rst is 1, the block SHALL be in IDLE with ready=0, error=0, rData=0 and the count at 0.
REQ-030 Reset asserted in WAIT or DONE SHALL abort the request: no array write occurs on that edge, and no ready pulse is produced afterwards.
REQ-031 A request present in the first cycle after rst falls SHALL be accepted normally.

Verification
REQ-032 With LATENCY=2: SW addr=0x10 wData=0xDEADBEEF, then LW addr=0x10 -> each request gives ready 2 cycles after acceptance; the load returns rData=0xDEADBEEF, error=0.
REQ-033 With word 0x10=0xDEADBEEF: SB addr=0x11 wData=0x000000AA, then LW addr=0x10 -> rData=0xDEADAAEF.
REQ-034 With word 0x10=0xDEAD80EF: LB addr=0x11 -> rData=0xFFFFFF80; LBU addr=0x11 -> 0x00000080; LH addr=0x12 -> 0xFFFFDEAD; LHU addr=0x12 -> 0x0000DEAD.
REQ-035 LW addr=0x13, SH addr=0x11, and a request with func3=011 -> each gives ready with error=1 and rData=0, and the array is unchanged.
REQ-036 SW to addr=0x4000 (DM_MEM_DEPTH=4096) wData=0x12345678, then LW addr=0x0 -> rData=0x12345678 (wrap-around).
REQ-037 Reset pulsed during WAIT of SW addr=0x20 -> no ready pulse, word 0x20 is unchanged, and the next request completes with the normal latency.
REQ-038 Back-to-back requests held continuously with LATENCY=1 -> ready pulses every 2 cycles, and each pulse carries the matching result.
